// File: rtl/btb_lookup_pipe.sv
// Read side of the 2-way, 8-set BTB: two-stage lookup (read in flight, then response), tag compare and per-set LRU.
// Latency 2 cycles from accept to resp_valid. A stalled response holds stage B, and stage A then replays its read each cycle.
module btb_lookup_pipe (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_pc,
    output logic         rd_en,
    output logic [2:0]   rd_index,
    input  logic [127:0] rd_set,
    input  logic         wr_en,
    input  logic [2:0]   wr_index,
    input  logic [127:0] wr_set,
    input  logic         wr_new,
    input  logic [2:0]   lru_index,
    output logic         lru_write,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_hit,
    output logic         resp_way,
    output logic         resp_taken,
    output logic [1:0]   resp_fsm,
    output logic [31:0]  resp_target
);

    logic         a_valid_q, a_valid_d;
    logic [31:0]  a_pc_q, a_pc_d;
    logic         b_valid_q, b_valid_d;
    logic [31:0]  b_pc_q, b_pc_d;
    logic [127:0] b_set_q, b_set_d;
    logic [7:0]   lru_q, lru_d;

    logic b_free, accept, replay, land, resp_hs;
    logic h1, h2;
    logic unused_pad;

    always_comb begin
        b_free    = !b_valid_q || resp_ready;
        req_ready = !a_valid_q || b_free;
        accept    = req_valid && req_ready;
        replay    = a_valid_q && !b_free;
        land      = a_valid_q && b_free;
        rd_en     = accept || replay;
        rd_index  = replay ? a_pc_q[4:2] : req_pc[4:2];
    end

    // Tag compare on the snapshot held in B; way 1 wins when both ways match.
    always_comb begin
        h1 = b_set_q[127] && (b_set_q[126:100] == b_pc_q[31:5]);
        h2 = b_set_q[63]  && (b_set_q[62:36]   == b_pc_q[31:5]);
        resp_valid  = b_valid_q;
        resp_hit    = h1 || h2;
        resp_way    = !h1 && h2;
        resp_fsm    = 2'b00;
        resp_target = b_pc_q + 32'd4;
        if (h1) begin
            resp_fsm    = b_set_q[67:66];
            resp_target = b_set_q[99:68];
        end else if (h2) begin
            resp_fsm    = b_set_q[3:2];
            resp_target = b_set_q[35:4];
        end
        resp_taken = resp_hit && resp_fsm[1];
    end

    assign unused_pad = ^{b_set_q[65:64], b_set_q[1:0]};

    always_comb begin
        resp_hs   = b_valid_q && resp_ready;
        a_valid_d = a_valid_q;
        a_pc_d    = a_pc_q;
        b_valid_d = b_valid_q;
        b_pc_d    = b_pc_q;
        b_set_d   = b_set_q;
        lru_d     = lru_q;

        if (accept) begin
            a_valid_d = 1'b1;
            a_pc_d    = req_pc;
        end else if (land) begin
            a_valid_d = 1'b0;
        end

        // A write landing on the same set as the returning read is newer than rd_set.
        if (land) begin
            b_valid_d = 1'b1;
            b_pc_d    = a_pc_q;
            b_set_d   = (wr_en && (wr_index == a_pc_q[4:2])) ? wr_set : rd_set;
        end else if (resp_hs) begin
            b_valid_d = 1'b0;
        end

        // The write-path toggle is applied last so it overrides a same-set hit update.
        if (resp_hs && resp_hit)
            lru_d[b_pc_q[4:2]] = resp_way;
        if (wr_en && wr_new)
            lru_d[wr_index] = ~lru_q[wr_index];
    end

    assign lru_write = lru_q[lru_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q <= 1'b0;
            a_pc_q    <= 32'd0;
            b_valid_q <= 1'b0;
            b_pc_q    <= 32'd0;
            b_set_q   <= 128'd0;
            lru_q     <= 8'hFF;
        end else begin
            a_valid_q <= a_valid_d;
            a_pc_q    <= a_pc_d;
            b_valid_q <= b_valid_d;
            b_pc_q    <= b_pc_d;
            b_set_q   <= b_set_d;
            lru_q     <= lru_d;
        end
    end

endmodule

// File: tb/tb_btb_lookup_pipe.sv
// Scoreboard bench for btb_lookup_pipe: a set-memory model feeds rd_set; expected responses queue on accept and pop on handshake.
module tb_btb_lookup_pipe;

    logic         clk, rst_n;
    logic         req_valid, req_ready;
    logic [31:0]  req_pc;
    logic         rd_en;
    logic [2:0]   rd_index;
    logic [127:0] rd_set;
    logic         wr_en;
    logic [2:0]   wr_index;
    logic [127:0] wr_set;
    logic         wr_new;
    logic [2:0]   lru_index;
    logic         lru_write;
    logic         resp_valid, resp_ready, resp_hit, resp_way, resp_taken;
    logic [1:0]   resp_fsm;
    logic [31:0]  resp_target;

    btb_lookup_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .rd_en(rd_en), .rd_index(rd_index), .rd_set(rd_set),
        .wr_en(wr_en), .wr_index(wr_index), .wr_set(wr_set), .wr_new(wr_new),
        .lru_index(lru_index), .lru_write(lru_write),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_taken(resp_taken), .resp_fsm(resp_fsm),
        .resp_target(resp_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  pc;
        logic [127:0] set;
        int           cyc;
        bit           lat;
    } entry_t;

    typedef struct packed {
        logic        hit;
        logic        way;
        logic        taken;
        logic [1:0]  fsm;
        logic [31:0] tgt;
    } exp_t;

    entry_t       sb_q[$];
    entry_t       mon_e;
    exp_t         mon_x;
    logic [127:0] mem [8];
    logic [127:0] shadow [8];
    logic [127:0] cur_set;
    logic [127:0] wset;
    bit           lat_en;
    int           cyc, n_resp, n_chk, n_err, resp_mark;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_way(input logic v, input logic [26:0] tag,
                                           input logic [31:0] tgt, input logic [1:0] fsm);
        return {v, tag, tgt, fsm, 2'b00};
    endfunction

    function automatic exp_t model(input logic [31:0] pc, input logic [127:0] set);
        exp_t        r;
        logic [63:0] w1, w2;
        logic        m1, m2;
        w1 = set[127:64];
        w2 = set[63:0];
        m1 = w1[63] && (w1[62:36] == pc[31:5]);
        m2 = w2[63] && (w2[62:36] == pc[31:5]);
        r.hit = m1 || m2;
        r.way = m1 ? 1'b0 : m2;
        r.fsm = m1 ? w1[3:2] : (m2 ? w2[3:2] : 2'b00);
        r.tgt = m1 ? w1[35:4] : (m2 ? w2[35:4] : pc + 32'd4);
        r.taken = r.hit && r.fsm[1];
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_set <= mem[rd_index];
        if (wr_en) mem[wr_index] <= wr_set;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready)
                sb_q.push_back('{req_pc, cur_set, cyc, lat_en});
            if (resp_valid && resp_ready) begin
                n_resp++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    mon_x = model(mon_e.pc, mon_e.set);
                    chk("resp_hit", resp_hit, mon_x.hit);
                    chk("resp_way", resp_way, mon_x.way);
                    chk("resp_taken", resp_taken, mon_x.taken);
                    chk("resp_fsm", resp_fsm, mon_x.fsm);
                    chk("resp_target", resp_target, mon_x.tgt);
                    if (mon_e.lat) chk("latency", cyc - mon_e.cyc, 2);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_set(input logic [2:0] idx, input logic [127:0] s, input logic nw);
        wr_en = 1'b1; wr_index = idx; wr_set = s; wr_new = nw;
        shadow[idx] = s;
        step();
        wr_en = 1'b0; wr_new = 1'b0;
    endtask

    task automatic send(input logic [31:0] pc);
        bit ok;
        ok = 0;
        req_valid = 1'b1; req_pc = pc; cur_set = shadow[pc[4:2]];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) chk("req_ready_timeout", 64'd0, 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (sb_q.size() == 0 && !resp_valid) break;
            step();
        end
        chk("drain", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        chk("watchdog", 64'd1, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        n_chk = 0; n_err = 0; n_resp = 0; cyc = 0; lat_en = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_pc = 32'd0; resp_ready = 1'b1;
        wr_en = 1'b0; wr_index = 3'd0; wr_set = 128'd0; wr_new = 1'b0;
        lru_index = 3'd0; cur_set = 128'd0; rd_set = 128'd0;

        // Reset state
        #12;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_target", resp_target, 32'h4);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_lru0", lru_write, 1);
        chk("rst_rd_en_idle", rd_en, 0);
        req_valid = 1'b1; #1;
        chk("rst_rd_en_follow", rd_en, 1);
        req_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) write_set(3'(i), 128'd0, 1'b0);

        // Miss on an empty set, with latency check
        lat_en = 1;
        send(32'h0000_1000);
        lat_en = 0;
        wait_drain();

        // Way-1 hit and LRU update
        write_set(3'd0, {mk_way(1'b1, 27'h80, 32'h0000_2000, 2'b11), 64'd0}, 1'b0);
        send(32'h0000_1000);
        wait_drain();
        lru_index = 3'd0; #1;
        chk("lru0_after_w1_hit", lru_write, 0);
        lru_index = 3'd1; #1;
        chk("lru1_untouched", lru_write, 1);

        // Backpressure: back-to-back requests with a 3-cycle stall
        resp_mark = n_resp;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_pc = 32'h0000_1000; cur_set = shadow[0];
        step();
        req_pc = 32'h0000_1004; cur_set = shadow[1];
        step();
        req_pc = 32'h0000_1008; cur_set = shadow[2];
        repeat (3) begin
            @(negedge clk);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_rd_en", rd_en, 1);
            chk("stall_rd_index", rd_index, 1);
            chk("stall_resp_valid", resp_valid, 1);
            chk("stall_resp_target", resp_target, 32'h0000_2000);
            step();
        end
        resp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        wait_drain();
        chk("stall_resp_count", n_resp - resp_mark, 3);

        // Write bypass: way-2 match arrives on wr_set while rd_set is stale
        wset = {shadow[0][127:64], mk_way(1'b1, 27'h180, 32'h4444_0000, 2'b01)};
        req_valid = 1'b1; req_pc = 32'h0000_3000; cur_set = wset;
        step();
        req_valid = 1'b0;
        wr_en = 1'b1; wr_index = 3'd0; wr_set = wset; wr_new = 1'b0;
        step();
        wr_en = 1'b0;
        shadow[0] = wset;
        wait_drain();
        lru_index = 3'd0; #1;
        chk("lru0_after_w2_hit", lru_write, 1);

        // LRU: write toggle collides with a way-1 hit handshake on set 5
        write_set(3'd5, {mk_way(1'b1, 27'h0, 32'h0000_5000, 2'b10), 64'd0}, 1'b0);
        for (int k = 0; k < 2; k++) begin
            req_valid = 1'b1; req_pc = 32'h0000_0014; cur_set = shadow[5];
            step();
            req_valid = 1'b0;
            step();
            wr_en = 1'b1; wr_index = 3'd5; wr_set = shadow[5]; wr_new = 1'b1;
            step();
            wr_en = 1'b0; wr_new = 1'b0;
            lru_index = 3'd5; #1;
            chk("lru5_write_wins", lru_write, (k == 0) ? 64'd0 : 64'd1);
            wait_drain();
        end

        // Reset while A and B are both valid
        write_set(3'd2, shadow[2], 1'b1);
        lru_index = 3'd2; #1;
        chk("lru2_toggled", lru_write, 0);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_pc = 32'h0000_1000; cur_set = shadow[0];
        step();
        req_pc = 32'h0000_1004; cur_set = shadow[1];
        step();
        req_valid = 1'b0;
        step();
        chk("pre_rst_resp_valid", resp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_lru2", lru_write, 1);
        sb_q.delete();
        resp_mark = n_resp;
        resp_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        repeat (6) step();
        chk("post_rst_no_resp", n_resp - resp_mark, 0);
        chk("post_rst_resp_valid", resp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
